// File: rtl/mem_arbiter_if.sv
// ======================================================================
// mem_arbiter_if: IFU, LSU and memory request/response bundle. Rev 1.0
// ======================================================================
`default_nettype none

interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  ifu_req_valid;
   logic [ADDR_W-1:0]     ifu_addr;
   logic                  ifu_req_ready;
   logic                  ifu_rsp_valid;
   logic [DATA_W-1:0]     ifu_rsp_data;
   logic                  ifu_rsp_err;

   logic                  lsu_req_valid;
   logic [ADDR_W-1:0]     lsu_addr;
   logic                  lsu_wen;
   logic [DATA_W-1:0]     lsu_wdata;
   logic [DATA_W/8-1:0]   lsu_wmask;
   logic                  lsu_req_ready;
   logic                  lsu_rsp_valid;
   logic [DATA_W-1:0]     lsu_rsp_data;
   logic                  lsu_rsp_err;

   logic                  mem_req_valid;
   logic [ADDR_W-1:0]     mem_addr;
   logic                  mem_wen;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_wmask;
   logic                  mem_req_ready;
   logic                  mem_rsp_valid;
   logic [DATA_W-1:0]     mem_rsp_data;

   // Arbiter side
   modport master (
      input  ifu_req_valid, ifu_addr,
      output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
      input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data
   );

   // Requestor/memory side
   modport slave (
      output ifu_req_valid, ifu_addr,
      input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
      output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data
   );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ======================================================================
// mem_arbiter: one-outstanding IFU/LSU memory arbiter, LSU priority. Rev 1.0
// ======================================================================
`default_nettype none

module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  wire logic     clk_i,
   input  wire logic     reset_i,
   mem_arbiter_if.master arb_if
);
   localparam int MASK_W = DATA_W / 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              owner_q, owner_d;   // 1 = LSU
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [MASK_W-1:0] wmask_q, wmask_d;
   logic              rst_dly_q;

   logic w_can_grant, w_lsu_grant, w_ifu_grant;
   logic w_busy, w_rsp_ok, w_timeout, w_rsp_fire, w_mem_act;

   // Grants are held off during reset and the cycle right after it
   assign w_can_grant = (state_q == S_IDLE) && !reset_i && !rst_dly_q;
   assign w_lsu_grant = w_can_grant && arb_if.lsu_req_valid;
   assign w_ifu_grant = w_can_grant && !arb_if.lsu_req_valid && arb_if.ifu_req_valid;

   assign w_busy     = !reset_i && ((state_q == S_REQ) || (state_q == S_WAIT));
   assign w_rsp_ok   = !reset_i && (state_q == S_WAIT) && arb_if.mem_rsp_valid;
   assign w_timeout  = w_busy && (cnt_q == 8'(TIMEOUT));
   assign w_rsp_fire = w_rsp_ok || w_timeout;
   assign w_mem_act  = !reset_i && (state_q == S_REQ);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      wen_d   = wen_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      case (state_q)
         S_IDLE: begin
            if (w_lsu_grant) begin
               owner_d = 1'b1;
               addr_d  = arb_if.lsu_addr;
               wen_d   = arb_if.lsu_wen;
               wdata_d = arb_if.lsu_wdata;
               wmask_d = arb_if.lsu_wmask;
               cnt_d   = 8'd0;
               state_d = S_REQ;
            end else if (w_ifu_grant) begin
               owner_d = 1'b0;
               addr_d  = arb_if.ifu_addr;
               wen_d   = 1'b0;
               wdata_d = '0;
               wmask_d = '0;
               cnt_d   = 8'd0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + 8'd1;
            if (w_timeout) begin
               state_d = S_IDLE;
            end else if (arb_if.mem_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (w_rsp_fire) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         owner_q   <= 1'b0;
         addr_q    <= '0;
         wen_q     <= 1'b0;
         wdata_q   <= '0;
         wmask_q   <= '0;
         rst_dly_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         wen_q     <= wen_d;
         wdata_q   <= wdata_d;
         wmask_q   <= wmask_d;
         rst_dly_q <= 1'b0;
      end
   end

   assign arb_if.ifu_req_ready = w_ifu_grant;
   assign arb_if.lsu_req_ready = w_lsu_grant;

   assign arb_if.mem_req_valid = w_mem_act;
   assign arb_if.mem_addr      = w_mem_act ? addr_q  : '0;
   assign arb_if.mem_wen       = w_mem_act ? wen_q   : 1'b0;
   assign arb_if.mem_wdata     = w_mem_act ? wdata_q : '0;
   assign arb_if.mem_wmask     = w_mem_act ? wmask_q : '0;

   // A real response in the timeout cycle wins over the abort
   assign arb_if.ifu_rsp_valid = w_rsp_fire && !owner_q;
   assign arb_if.ifu_rsp_data  = (w_rsp_ok && !owner_q) ? arb_if.mem_rsp_data : '0;
   assign arb_if.ifu_rsp_err   = w_timeout && !w_rsp_ok && !owner_q;
   assign arb_if.lsu_rsp_valid = w_rsp_fire && owner_q;
   assign arb_if.lsu_rsp_data  = (w_rsp_ok && owner_q) ? arb_if.mem_rsp_data : '0;
   assign arb_if.lsu_rsp_err   = w_timeout && !w_rsp_ok && owner_q;
endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ======================================================================
// tb_mem_arbiter: directed and random checks against a transaction model. Rev 1.0
// ======================================================================
`default_nettype none

module tb_mem_arbiter;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .arb_if  (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Transaction-level model: at most one pending transaction
   bit          m_busy, m_issued, m_lsu, m_after_reset;
   int          m_age;
   logic [31:0] m_addr, m_wdata;
   logic        m_wen;
   logic [3:0]  m_wmask;

   logic        e_ifu_rdy, e_lsu_rdy, e_mval, e_mwen, e_fire;
   logic        e_ifu_rv, e_ifu_re, e_lsu_rv, e_lsu_re;
   logic [31:0] e_maddr, e_mwdata, e_ifu_rd, e_lsu_rd;
   logic [3:0]  e_mwmask;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic eval_model();
      bit can, ok, to;
      e_ifu_rdy = 0; e_lsu_rdy = 0; e_mval = 0; e_mwen = 0; e_fire = 0;
      e_ifu_rv = 0; e_ifu_re = 0; e_lsu_rv = 0; e_lsu_re = 0;
      e_maddr = 0; e_mwdata = 0; e_ifu_rd = 0; e_lsu_rd = 0; e_mwmask = 0;
      if (!reset) begin
         can       = !m_busy && !m_after_reset;
         e_lsu_rdy = can && bus.lsu_req_valid;
         e_ifu_rdy = can && !bus.lsu_req_valid && bus.ifu_req_valid;
         e_mval    = m_busy && !m_issued;
         if (e_mval) begin
            e_maddr = m_addr; e_mwen = m_wen; e_mwdata = m_wdata; e_mwmask = m_wmask;
         end
         ok     = m_busy && m_issued && bus.mem_rsp_valid;
         to     = m_busy && (m_age == TO) && !ok;
         e_fire = ok || to;
         if (m_lsu) begin
            e_lsu_rv = e_fire; e_lsu_re = to; e_lsu_rd = ok ? bus.mem_rsp_data : 32'h0;
         end else begin
            e_ifu_rv = e_fire; e_ifu_re = to; e_ifu_rd = ok ? bus.mem_rsp_data : 32'h0;
         end
      end
   endtask

   task automatic compare_dut();
      chk("ifu_req_ready", 32'(bus.ifu_req_ready), 32'(e_ifu_rdy));
      chk("lsu_req_ready", 32'(bus.lsu_req_ready), 32'(e_lsu_rdy));
      chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(e_mval));
      chk("mem_addr",      bus.mem_addr,           e_maddr);
      chk("mem_wen",       32'(bus.mem_wen),       32'(e_mwen));
      chk("mem_wdata",     bus.mem_wdata,          e_mwdata);
      chk("mem_wmask",     32'(bus.mem_wmask),     32'(e_mwmask));
      chk("ifu_rsp_valid", 32'(bus.ifu_rsp_valid), 32'(e_ifu_rv));
      chk("ifu_rsp_data",  bus.ifu_rsp_data,       e_ifu_rd);
      chk("ifu_rsp_err",   32'(bus.ifu_rsp_err),   32'(e_ifu_re));
      chk("lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 32'(e_lsu_rv));
      chk("lsu_rsp_data",  bus.lsu_rsp_data,       e_lsu_rd);
      chk("lsu_rsp_err",   32'(bus.lsu_rsp_err),   32'(e_lsu_re));
   endtask

   task automatic advance_model();
      if (reset) begin
         m_busy = 0; m_after_reset = 1;
      end else begin
         m_after_reset = 0;
         if (e_lsu_rdy) begin
            m_busy = 1; m_issued = 0; m_age = 0; m_lsu = 1;
            m_addr = bus.lsu_addr; m_wen = bus.lsu_wen;
            m_wdata = bus.lsu_wdata; m_wmask = bus.lsu_wmask;
         end else if (e_ifu_rdy) begin
            m_busy = 1; m_issued = 0; m_age = 0; m_lsu = 0;
            m_addr = bus.ifu_addr; m_wen = 0; m_wdata = 0; m_wmask = 0;
         end else if (m_busy) begin
            if (e_fire) m_busy = 0;
            else begin
               if (!m_issued && bus.mem_req_ready) m_issued = 1;
               m_age++;
            end
         end
      end
   endtask

   // Called just after a falling edge with inputs already driven
   task automatic step();
      #1;
      eval_model();
      compare_dut();
      advance_model();
      @(negedge clk);
   endtask

   task automatic quiet();
      bus.ifu_req_valid = 0; bus.ifu_addr = 0;
      bus.lsu_req_valid = 0; bus.lsu_addr = 0; bus.lsu_wen = 0;
      bus.lsu_wdata = 0; bus.lsu_wmask = 0;
      bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = 0;
   endtask

   initial begin
      int k_seen;
      reset = 1;
      quiet();
      m_busy = 0; m_issued = 0; m_lsu = 0; m_after_reset = 1; m_age = 0;
      m_addr = 0; m_wdata = 0; m_wen = 0; m_wmask = 0;
      @(posedge clk);
      @(negedge clk);

      // Reset: no grant while in reset or the cycle after
      bus.lsu_req_valid = 1;
      #1 chk("rst_lsu_ready", 32'(bus.lsu_req_ready), 32'h0);
      step();
      reset = 0;
      #1 chk("post_rst_lsu_ready", 32'(bus.lsu_req_ready), 32'h0);
      step();
      quiet();
      step();

      // IFU-only fetch
      bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0000; bus.mem_req_ready = 1;
      #1 chk("ifu_accept", 32'(bus.ifu_req_ready), 32'h1);
      step();
      bus.ifu_req_valid = 0;
      #1 chk("ifu_mem_addr", bus.mem_addr, 32'h8000_0000);
      chk("ifu_mem_wen", 32'(bus.mem_wen), 32'h0);
      step();
      bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h0010_0073;
      #1 chk("ifu_rsp_data", bus.ifu_rsp_data, 32'h0010_0073);
      chk("ifu_rsp_valid", 32'(bus.ifu_rsp_valid), 32'h1);
      step();
      bus.mem_rsp_valid = 0;
      #1 chk("ifu_rsp_one_cycle", 32'(bus.ifu_rsp_valid), 32'h0);
      step();

      // Contention: LSU store wins, IFU served afterwards
      bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0004;
      bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_1000; bus.lsu_wen = 1;
      bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wmask = 4'hF;
      #1 chk("cont_lsu_ready", 32'(bus.lsu_req_ready), 32'h1);
      chk("cont_ifu_ready", 32'(bus.ifu_req_ready), 32'h0);
      step();
      bus.lsu_req_valid = 0;
      #1 chk("cont_mem_wen", 32'(bus.mem_wen), 32'h1);
      chk("cont_mem_wmask", 32'(bus.mem_wmask), 32'hF);
      chk("cont_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      step();
      bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h1234_5678;
      #1 chk("cont_lsu_rsp", 32'(bus.lsu_rsp_valid), 32'h1);
      step();
      bus.mem_rsp_valid = 0;
      #1 chk("cont_ifu_after", 32'(bus.ifu_req_ready), 32'h1);
      step();
      bus.ifu_req_valid = 0;
      #1 chk("cont_ifu_addr", bus.mem_addr, 32'h8000_0004);
      step();
      bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'hCAFE_0001;
      step();
      bus.mem_rsp_valid = 0;

      // Backpressure: request held stable while memory stalls
      bus.lsu_req_valid = 1; bus.lsu_addr = 32'h0000_0ABC; bus.lsu_wen = 0;
      bus.lsu_wdata = 32'h5555_AAAA; bus.lsu_wmask = 4'h3; bus.mem_req_ready = 0;
      step();
      bus.lsu_req_valid = 0;
      for (int i = 0; i < 5; i++) begin
         #1 chk("bp_valid", 32'(bus.mem_req_valid), 32'h1);
         chk("bp_addr", bus.mem_addr, 32'h0000_0ABC);
         step();
      end
      bus.mem_req_ready = 1;
      step();
      #1 chk("bp_in_wait", 32'(bus.mem_req_valid), 32'h0);
      bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h7777_0000;
      step();
      bus.mem_rsp_valid = 0;

      // Timeout: LSU load, memory never responds
      bus.lsu_req_valid = 1; bus.lsu_addr = 32'h0000_0040; bus.lsu_wen = 0;
      step();
      bus.lsu_req_valid = 0;
      k_seen = -1;
      for (int k = 0; k < 20 && k_seen < 0; k++) begin
         #1;
         if (bus.lsu_rsp_valid) begin
            k_seen = k;
            chk("to_err", 32'(bus.lsu_rsp_err), 32'h1);
            chk("to_data", bus.lsu_rsp_data, 32'h0);
         end
         step();
      end
      chk("to_cycle", 32'(k_seen), 32'd8);

      // Reset mid-WAIT drops the transaction
      bus.ifu_req_valid = 1; bus.ifu_addr = 32'h0000_1000;
      step();
      bus.ifu_req_valid = 0;
      step();
      reset = 1;
      step();
      reset = 0; bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'hBAD0_BAD0;
      #1 chk("rstw_ifu_rsp", 32'(bus.ifu_rsp_valid), 32'h0);
      chk("rstw_lsu_rsp", 32'(bus.lsu_rsp_valid), 32'h0);
      step();
      bus.mem_rsp_valid = 0;
      bus.ifu_req_valid = 1; bus.ifu_addr = 32'h0000_2000;
      #1 chk("rstw_next_accept", 32'(bus.ifu_req_ready), 32'h1);
      step();
      bus.ifu_req_valid = 0;
      step();
      bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h0000_2222;
      #1 chk("rstw_next_rsp", bus.ifu_rsp_data, 32'h0000_2222);
      step();

      // Spurious response in IDLE is ignored
      bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'hFFFF_FFFF;
      #1 chk("spur_ifu", 32'(bus.ifu_rsp_valid), 32'h0);
      chk("spur_lsu", 32'(bus.lsu_rsp_valid), 32'h0);
      step();
      bus.mem_rsp_valid = 0; bus.lsu_req_valid = 1;
      #1 chk("spur_still_idle", 32'(bus.lsu_req_ready), 32'h1);
      step();

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         reset             = ($urandom_range(0, 199) == 0);
         bus.ifu_req_valid = 1'($urandom_range(0, 1));
         bus.ifu_addr      = $urandom;
         bus.lsu_req_valid = ($urandom_range(0, 2) == 0);
         bus.lsu_addr      = $urandom;
         bus.lsu_wen       = 1'($urandom_range(0, 1));
         bus.lsu_wdata     = $urandom;
         bus.lsu_wmask     = 4'($urandom_range(0, 15));
         bus.mem_req_ready = 1'($urandom_range(0, 1));
         bus.mem_rsp_valid = ($urandom_range(0, 3) == 0);
         bus.mem_rsp_data  = $urandom;
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, width of all address buses.
REQ-002 Parameter DATA_W, 32, width of all data buses; wmask width is DATA_W/8.
REQ-003 Parameter TIMEOUT, 255, maximum cycles spent in REQ+WAIT before an aborted response; legal range 2..255.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ifu_req_valid  in  1  fetch request pending; ifu_addr  in  ADDR_W  fetch address.
REQ-007 ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-008 ifu_rsp_valid  out  1  one-cycle fetch response strobe; ifu_rsp_data  out  DATA_W  fetched word; ifu_rsp_err  out  1  timeout flag.
REQ-009 lsu_req_valid  in  1; lsu_addr  in  ADDR_W; lsu_wen  in  1 (1=store); lsu_wdata  in  DATA_W; lsu_wmask  in  DATA_W/8.
REQ-010 lsu_req_ready  out  1; lsu_rsp_valid  out  1; lsu_rsp_data  out  DATA_W; lsu_rsp_err  out  1.
REQ-011 mem_req_valid  out  1; mem_addr  out  ADDR_W; mem_wen  out  1; mem_wdata  out  DATA_W; mem_wmask  out  DATA_W/8.
REQ-012 mem_req_ready  in  1  memory accepts request; mem_rsp_valid  in  1; mem_rsp_data  in  DATA_W.

Function
REQ-013 Block SHALL share one memory port between IFU and LSU with exactly one outstanding transaction, using FSM states IDLE, REQ, WAIT.
REQ-014 IDLE: if lsu_req_valid, assert lsu_req_ready combinationally, latch LSU fields, owner=LSU, go REQ; else if ifu_req_valid, assert ifu_req_ready, latch ifu_addr with wen=0, wmask=0, wdata=0, owner=IFU, go REQ; else stay IDLE.
REQ-015 Simultaneous IFU and LSU requests in IDLE SHALL grant LSU; IFU stays pending with ifu_req_ready=0.
REQ-016 ifu_req_ready and lsu_req_ready SHALL be 0 in REQ and WAIT and never both 1.
REQ-017 REQ: mem_req_valid=1 with latched fields held stable; on mem_req_ready=1 go WAIT next cycle.
REQ-018 mem_req_valid and all mem_* outputs SHALL be 0 outside REQ.
REQ-019 WAIT: on mem_rsp_valid=1 assert owner's rsp_valid for exactly that cycle, rsp_data=mem_rsp_data, rsp_err=0, go IDLE.
REQ-020 Non-owner rsp_valid SHALL be 0; rsp_data SHALL be 0 whenever rsp_valid=0.
REQ-021 mem_rsp_valid in IDLE or REQ SHALL be ignored.
REQ-022 8-bit timeout counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT.
REQ-023 When counter reaches TIMEOUT with no response, owner's rsp_valid=1, rsp_err=1, rsp_data=0 that cycle; go IDLE.
REQ-024 mem_rsp_valid in the same cycle the counter reaches TIMEOUT SHALL win: normal response, rsp_err=0.
REQ-025 Minimum latency: accept in cycle N, mem_req_valid in N+1, response no earlier than N+2; next acceptance no earlier than the cycle after the response.

Reset
REQ-026 reset=1 at a clock edge SHALL force state IDLE, counter 0, owner IFU, latched fields 0, regardless of state.
REQ-027 While in reset and the cycle after, all ready, rsp_valid, rsp_err and mem_* outputs SHALL be 0.
REQ-028 Reset during REQ or WAIT SHALL drop the transaction silently; no response is generated for it.

Verification
REQ-029 IFU only: ifu_addr=0x80000000, mem_req_ready=1, mem_rsp_data=0x00100073 two cycles later -> mem_addr=0x80000000, mem_wen=0, ifu_rsp_valid one cycle with data 0x00100073, err=0.
REQ-030 Contention: IFU 0x80000004 and LSU store 0x80001000/0xDEADBEEF/mask 0xF same cycle -> LSU served first (mem_wen=1, mem_wmask=0xF); IFU accepted the cycle after LSU response.
REQ-031 Backpressure: mem_req_ready low 5 cycles in REQ -> mem_req_valid and fields held stable 5 cycles, WAIT entered after ready rises.
REQ-032 Timeout: TIMEOUT=8, LSU load, mem_rsp_valid never asserted -> lsu_rsp_valid=1, lsu_rsp_err=1, data 0 at 8th cycle after REQ entry; FSM returns IDLE.
REQ-033 Reset mid-WAIT: reset asserted one cycle, then mem_rsp_valid pulses -> no rsp_valid on either side, FSM IDLE, next IFU request served normally.
REQ-034 Spurious response: mem_rsp_valid pulse in IDLE -> no rsp_valid, no state change.
